// File: rtl/dx_issue_stage_if.sv
// rtl/dx_issue_stage_if.sv - fetch, execute and writeback signals of the decode/issue stage
interface dx_issue_stage_if #(
  parameter int REG_SIZE      = 8,
  parameter int INSN_OPC_SIZE = 4,
  parameter int INSN_SIZE     = 16,
  parameter int REG_ID_SIZE   = 4
) ();
  logic                     F_insn_valid;
  logic [INSN_SIZE-1:0]     F_insn;
  logic                     F_insn_ready;
  logic                     DX_valid;
  logic [INSN_OPC_SIZE-1:0] DX_insn_opc;
  logic [REG_ID_SIZE-1:0]   DX_dst;
  logic [REG_SIZE-1:0]      src_0_data_ALU;
  logic [REG_SIZE-1:0]      src_1_data_ALU;
  logic                     X_ready;
  logic                     wb_en;
  logic [REG_ID_SIZE-1:0]   wb_addr;
  logic [REG_SIZE-1:0]      wb_data;

  modport master (
    output F_insn_valid, F_insn, X_ready, wb_en, wb_addr, wb_data,
    input  F_insn_ready, DX_valid, DX_insn_opc, DX_dst, src_0_data_ALU, src_1_data_ALU
  );

  modport slave (
    input  F_insn_valid, F_insn, X_ready, wb_en, wb_addr, wb_data,
    output F_insn_ready, DX_valid, DX_insn_opc, DX_dst, src_0_data_ALU, src_1_data_ALU
  );
endinterface

// File: rtl/dx_issue_stage.sv
// rtl/dx_issue_stage.sv - decode/issue stage: register file, pending-write scoreboard, DX register
// Optional macro DX_WB_BYPASS_EN: forward writeback data/clear into the same-cycle issue.
module dx_issue_stage #(
  parameter int REG_SIZE      = 8,
  parameter int INSN_OPC_SIZE = 4,
  parameter int INSN_SIZE     = 16,
  parameter int REG_ID_SIZE   = 4
) (
  input logic              clk,
  input logic              rst_n,
  dx_issue_stage_if.slave  io
);
  localparam int NUM_REGS = 1 << REG_ID_SIZE;

  logic [REG_SIZE-1:0]      rf_q [NUM_REGS];
  logic [REG_SIZE-1:0]      rf_d [NUM_REGS];
  logic [NUM_REGS-1:0]      pend_q, pend_d;
  logic                     dx_valid_q, dx_valid_d;
  logic [INSN_OPC_SIZE-1:0] dx_opc_q, dx_opc_d;
  logic [REG_ID_SIZE-1:0]   dx_dst_q, dx_dst_d;
  logic [REG_SIZE-1:0]      src0_q, src0_d;
  logic [REG_SIZE-1:0]      src1_q, src1_d;

  logic [INSN_OPC_SIZE-1:0] opc;
  logic [REG_ID_SIZE-1:0]   dst, rs0, rs1;
  logic                     is_nop, hazard, ready, xfer;
  logic [NUM_REGS-1:0]      wb_clr, pend_chk;
  logic [REG_SIZE-1:0]      op0, op1;

  assign opc    = io.F_insn[15:12];
  assign dst    = io.F_insn[11:8];
  assign rs0    = io.F_insn[7:4];
  assign rs1    = io.F_insn[3:0];
  assign is_nop = (opc == '0);

  always_comb begin
    wb_clr = '0;
    if (io.wb_en) wb_clr[io.wb_addr] = 1'b1;
  end

`ifdef DX_WB_BYPASS_EN
  // A retiring write unblocks its dependents and supplies their operand in the same cycle.
  assign pend_chk = pend_q & ~wb_clr;

  always_comb begin
    op0 = rf_q[rs0];
    op1 = rf_q[rs1];
    if (io.wb_en && io.wb_addr == rs0) op0 = io.wb_data;
    if (io.wb_en && io.wb_addr == rs1) op1 = io.wb_data;
    if (rs0 == '0) op0 = '0;
    if (rs1 == '0) op1 = '0;
  end
`else
  assign pend_chk = pend_q;

  always_comb begin
    op0 = (rs0 == '0) ? '0 : rf_q[rs0];
    op1 = (rs1 == '0) ? '0 : rf_q[rs1];
  end
`endif

  assign hazard = !is_nop && (pend_chk[rs0] || pend_chk[rs1] || pend_chk[dst]);
  assign ready  = (!dx_valid_q || io.X_ready) && !hazard;
  assign xfer   = io.F_insn_valid && ready;

  always_comb begin
    rf_d = rf_q;
    if (io.wb_en && io.wb_addr != '0) rf_d[io.wb_addr] = io.wb_data;
  end

  // Clear first so that an issue to the same register in this cycle keeps it pending.
  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (xfer && !is_nop && dst != '0) pend_d[dst] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    dx_valid_d = dx_valid_q;
    dx_opc_d   = dx_opc_q;
    dx_dst_d   = dx_dst_q;
    src0_d     = src0_q;
    src1_d     = src1_q;
    if (xfer) begin
      dx_valid_d = 1'b1;
      dx_opc_d   = opc;
      dx_dst_d   = dst;
      src0_d     = is_nop ? '0 : op0;
      src1_d     = is_nop ? '0 : op1;
    end else if (io.X_ready) begin
      dx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      pend_q     <= '0;
      dx_valid_q <= 1'b0;
      dx_opc_q   <= '0;
      dx_dst_q   <= '0;
      src0_q     <= '0;
      src1_q     <= '0;
    end else begin
      rf_q       <= rf_d;
      pend_q     <= pend_d;
      dx_valid_q <= dx_valid_d;
      dx_opc_q   <= dx_opc_d;
      dx_dst_q   <= dx_dst_d;
      src0_q     <= src0_d;
      src1_q     <= src1_d;
    end
  end

  assign io.F_insn_ready   = ready;
  assign io.DX_valid       = dx_valid_q;
  assign io.DX_insn_opc    = dx_opc_q;
  assign io.DX_dst         = dx_dst_q;
  assign io.src_0_data_ALU = src0_q;
  assign io.src_1_data_ALU = src1_q;
endmodule

// File: tb/tb_dx_issue_stage.sv
// tb/tb_dx_issue_stage.sv - directed self-checking bench for dx_issue_stage
module tb_dx_issue_stage;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dx_issue_stage_if bus ();

  dx_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dx(input string tag, input logic v, input logic [3:0] opc,
                          input logic [3:0] dst, input logic [7:0] s0, input logic [7:0] s1);
    check({tag, ".valid"}, {31'd0, bus.DX_valid}, {31'd0, v});
    check({tag, ".opc"},   {28'd0, bus.DX_insn_opc}, {28'd0, opc});
    check({tag, ".dst"},   {28'd0, bus.DX_dst}, {28'd0, dst});
    check({tag, ".src0"},  {24'd0, bus.src_0_data_ALU}, {24'd0, s0});
    check({tag, ".src1"},  {24'd0, bus.src_1_data_ALU}, {24'd0, s1});
  endtask

  task automatic wb(input logic [3:0] a, input logic [7:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.F_insn_valid = 1'b0; bus.F_insn = '0; bus.X_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    #12;
    check_dx("reset", 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    check("reset.ready", {31'd0, bus.F_insn_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // basic ADD r5,r3,r4
    wb(4'd3, 8'h12);
    wb(4'd4, 8'h05);
    bus.F_insn = 16'h1534; bus.F_insn_valid = 1'b1; #1;
    check("add.ready", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    check_dx("add", 1'b1, 4'h1, 4'h5, 8'h12, 8'h05);

    // SUB r6,r5,r3 held on r5
    bus.F_insn = 16'h2653; #1;
    check("sub.stall0", {31'd0, bus.F_insn_ready}, 32'd0);
    tick();
    check("sub.drain", {31'd0, bus.DX_valid}, 32'd0);
    check("sub.stall1", {31'd0, bus.F_insn_ready}, 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 8'h17; #1;
`ifdef DX_WB_BYPASS_EN
    check("sub.ready_w", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    bus.wb_en = 1'b0;
`else
    check("sub.ready_w", {31'd0, bus.F_insn_ready}, 32'd0);
    tick();
    bus.wb_en = 1'b0; #1;
    check("sub.ready_w1", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
`endif
    check_dx("sub", 1'b1, 4'h2, 4'h6, 8'h17, 8'h12);
    bus.F_insn_valid = 1'b0;
    wb(4'd6, 8'h29);

    // back-pressure from execute
    bus.X_ready = 1'b0;
    bus.F_insn = 16'h3834; bus.F_insn_valid = 1'b1;
    tick();
    check_dx("stall.load", 1'b1, 4'h3, 4'h8, 8'h12, 8'h05);
    bus.F_insn = 16'h4936;
    for (int i = 0; i < 3; i++) begin
      check("stall.ready", {31'd0, bus.F_insn_ready}, 32'd0);
      tick();
      check_dx("stall.hold", 1'b1, 4'h3, 4'h8, 8'h12, 8'h05);
    end
    bus.X_ready = 1'b1; #1;
    check("stall.release", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    check_dx("stall.next", 1'b1, 4'h4, 4'h9, 8'h12, 8'h29);
    bus.F_insn_valid = 1'b0;
    wb(4'd8, 8'h01);
    wb(4'd9, 8'h02);

    // r0 reads zero and never goes pending
    wb(4'd0, 8'hFF);
    bus.F_insn = 16'h5A00; bus.F_insn_valid = 1'b1;
    tick();
    check_dx("r0.read", 1'b1, 4'h5, 4'hA, 8'h00, 8'h00);
    bus.F_insn = 16'h6003;
    tick();
    check_dx("r0.dst", 1'b1, 4'h6, 4'h0, 8'h00, 8'h12);
    bus.F_insn = 16'h7B00; #1;
    check("r0.notpend", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    check_dx("r0.after", 1'b1, 4'h7, 4'hB, 8'h00, 8'h00);

    // NOP ignores the scoreboard
    bus.F_insn = 16'h1734;
    tick();
    bus.F_insn = 16'h0000; #1;
    check("nop.ready", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    check_dx("nop", 1'b1, 4'h0, 4'h0, 8'h00, 8'h00);
    bus.F_insn = 16'h2C70; #1;
    check("r7.pend", {31'd0, bus.F_insn_ready}, 32'd0);

    // asynchronous reset during a hazard stall
    #2 rst_n = 1'b0; #1;
    check_dx("areset", 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    check("areset.ready", {31'd0, bus.F_insn_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post.ready", {31'd0, bus.F_insn_ready}, 32'd1);
    tick();
    check_dx("post", 1'b1, 4'h2, 4'hC, 8'h00, 8'h00);
    bus.F_insn_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dx_issue_stage.md
# dx_issue_stage

Decode/issue stage that feeds the ALU. It accepts 16-bit instruction words from fetch over a valid/ready handshake, decodes them, and reads operands from an internal 16×REG_SIZE register file. A per-register pending-write scoreboard blocks RAW/WAW hazards. The stage holds the DX pipeline register that drives the ALU's opcode and operand inputs, and it takes retired results back through a writeback port.

## Interface
- REG_SIZE, 8: data register width.
- INSN_OPC_SIZE, 4: opcode field width.
- INSN_SIZE, 16: instruction width; format [15:12] opc, [11:8] dst, [7:4] src0, [3:0] src1.
- REG_ID_SIZE, 4: register index width (16 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- F_insn_valid  in  1  fetch presents an instruction.
- F_insn  in  INSN_SIZE  instruction word.
- F_insn_ready  out  1  stage accepts F_insn this cycle.
- DX_valid  out  1  DX register holds an instruction for the ALU.
- DX_insn_opc  out  INSN_OPC_SIZE  opcode to the ALU.
- DX_dst  out  REG_ID_SIZE  destination register, carried down the pipe.
- src_0_data_ALU  out  REG_SIZE  operand 0.
- src_1_data_ALU  out  REG_SIZE  operand 1.
- X_ready  in  1  execute stage consumes DX this cycle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  REG_ID_SIZE  writeback register.
- wb_data  in  REG_SIZE  writeback value.

## Operation
- Opcode 4'h0 is NOP. A NOP reads nothing, writes nothing and is never hazard-stalled. Every other opcode reads src0 and src1 and writes dst.
- r0 always reads 0. Writes to r0 are discarded and r0 is never marked pending.
- Scoreboard: 16 pending bits.
  - A bit is set when a non-NOP instruction with dst≠0 issues.
  - A bit is cleared when wb_en is high with that wb_addr.
- Hazard: a non-NOP instruction is blocked if src0, src1 or dst has its pending bit set.
- Issue: F_insn_ready = (!DX_valid | X_ready) & !hazard. F_insn_ready may depend on the F_insn content.
- Transfer occurs when F_insn_valid & F_insn_ready. On transfer, the DX register loads:
  - DX_valid=1, the opcode and dst;
  - operands read from the register file at the current cycle.
- If X_ready and there is no transfer, DX_valid←0. The other DX fields hold their last values.
- If DX_valid & !X_ready, all DX outputs hold.
- Register file write happens at the clock edge when wb_en & wb_addr≠0.
- Same cycle, wb clear and issue-set on the same register: the set wins, so the bit stays pending.
- All operand arithmetic is done by the ALU. This stage performs no width conversion.

## Timing
- Reset (asynchronous assert): DX_valid=0, DX_insn_opc=0, DX_dst=0, src_0_data_ALU=0, src_1_data_ALU=0. All scoreboard bits are 0 and all registers are 0. F_insn_ready comes out of reset as 1 (DX empty, no hazards).
- Latency: an instruction accepted at edge N is on the DX outputs from edge N to the ALU in that cycle. Throughput is 1 instruction/cycle with no hazards.
- A reset asserted mid-stall drops the stalled instruction and all pending bits. Fetch must re-present it.
- A write to register R retires in cycle W. Whether a dependent instruction on R issues in W or W+1 is set by the configuration below.

## Configuration
- DX_WB_BYPASS_EN defined:
  - The hazard check uses pending bits with the current-cycle wb clear already applied.
  - An operand read where wb_addr equals the source (≠0) returns wb_data.
  - A dependent instruction issues in the writeback cycle W.
- DX_WB_BYPASS_EN undefined:
  - The hazard check uses registered pending bits only.
  - Operands come from the register file array only.
  - A dependent instruction issues in W+1 and sees the written value.

## Test plan
- Reset, then write r3=0x12 and r4=0x05 via wb, then issue ADD r5,r3,r4 (0x1534 with ADD=1) with X_ready=1 → next cycle DX_valid=1, opc=1, DX_dst=5, src_0=0x12, src_1=0x05, and r5 is pending.
- Issue ADD r5,r3,r4 then SUB r6,r5,r3 back-to-back → SUB is held with F_insn_ready=0. Assert wb_en r5=0x17 in cycle W:
  - with DX_WB_BYPASS_EN, SUB issues in W with src_0=0x17;
  - without it, SUB issues in W+1 with src_0=0x17.
- Hold X_ready=0 for 3 cycles with DX_valid=1 and a new valid instruction pending → F_insn_ready=0 and the DX outputs are unchanged. When X_ready rises, the new instruction loads on that edge.
- Issue an instruction reading r0, after a wb_en to r0 with 0xFF → operand=0x00 and scoreboard bit 0 stays 0.
- Issue ADD r7,… followed by NOP (0x0000) → the NOP issues the next cycle despite r7 being pending, and DX_insn_opc=0.
- Assert rst_n=0 mid-cycle while a hazard stall is active → all outputs go 0 immediately (asynchronously). After release, F_insn_ready=1 and the previously pending register no longer blocks.
